// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler
//   Converts a UART RX byte stream into one wide payload word plus a 6-bit
//   control field for the downstream coprocessor.
//   Frame: SYNC_BYTE, CTRL, N payload bytes (N = WIDTH_DIN/8), and an optional
//   trailing CHK byte. Malformed or stalled frames are dropped and flagged.
//
//   Optional feature macro: FRAME_CHECKSUM_EN
//     defined   : the frame carries a trailing CHK byte (XOR of CTRL and all
//                 payload bytes); a mismatch drops the frame with frame_err.
//     undefined : no CHK byte; the word is emitted after the Nth payload byte.
//
// Ports
//   clk        in   1          system clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   rx_data    in   8          received byte
//   rx_valid   in   1          rx_data valid this cycle (back-to-back allowed)
//   din        out  WIDTH_DIN  assembled payload, first payload byte in MSBs
//   din_valid  out  1          1-cycle pulse: din/control hold a new frame
//   control    out  6          CTRL byte bits [5:0] of the emitted frame
//   frame_err  out  1          1-cycle pulse: frame dropped
module uart_frame_assembler #(
  parameter int         WIDTH_DIN      = 128,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [WIDTH_DIN-1:0] din,
  output logic                 din_valid,
  output logic [5:0]           control,
  output logic                 frame_err
);

  localparam int N  = WIDTH_DIN / 8;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

`ifdef FRAME_CHECKSUM_EN
  // The whole payload must be held until the CHK byte arrives.
  localparam int SW = WIDTH_DIN;
`else
  // The last payload byte goes straight from rx_data into din.
  localparam int SW = (WIDTH_DIN > 8) ? WIDTH_DIN - 8 : 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CTRL,
    S_PAYLOAD
`ifdef FRAME_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t               r_state;
  logic [SW-1:0]        r_shift;
  logic [5:0]           r_ctrl_shadow;
  logic [CW-1:0]        r_count;
  logic [IW-1:0]        r_idle;
  logic [WIDTH_DIN-1:0] r_din;
  logic [5:0]           r_control;
  logic                 r_din_valid;
  logic                 r_frame_err;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]           r_chk;
`else
  logic [WIDTH_DIN-1:0] w_emit;
  assign w_emit = WIDTH_DIN'({r_shift, rx_data});
`endif

  logic [SW-1:0] w_shift_next;

  generate
    if (SW > 8) begin : g_shift
      assign w_shift_next = {r_shift[SW-9:0], rx_data};
    end else begin : g_shift_byte
      assign w_shift_next = SW'(rx_data);
    end
  endgenerate

  // EMIT is not a separate state: the load of din/control and the din_valid
  // pulse happen on the same edge that accepts the last frame byte, and the
  // FSM returns to IDLE so a new SYNC byte is accepted on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_ctrl_shadow <= '0;
      r_count       <= '0;
      r_idle        <= '0;
      r_din         <= '0;
      r_control     <= '0;
      r_din_valid   <= 1'b0;
      r_frame_err   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_chk         <= '0;
`endif
    end else begin
      r_din_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (rx_valid) begin
        // A byte on the expiry cycle wins over the timeout.
        r_idle <= '0;
        unique case (r_state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) r_state <= S_CTRL;
          end
          S_CTRL: begin
            if (rx_data[7:6] == 2'b00) begin
              r_ctrl_shadow <= rx_data[5:0];
              r_count       <= '0;
`ifdef FRAME_CHECKSUM_EN
              r_chk         <= rx_data;
`endif
              r_state       <= S_PAYLOAD;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          S_PAYLOAD: begin
            r_shift <= w_shift_next;
            r_count <= r_count + CW'(1);
`ifdef FRAME_CHECKSUM_EN
            r_chk   <= r_chk ^ rx_data;
            if (r_count == CNT_LAST) r_state <= S_CHECK;
`else
            if (r_count == CNT_LAST) begin
              r_din       <= w_emit;
              r_control   <= r_ctrl_shadow;
              r_din_valid <= 1'b1;
              r_state     <= S_IDLE;
            end
`endif
          end
`ifdef FRAME_CHECKSUM_EN
          S_CHECK: begin
            if (rx_data == r_chk) begin
              r_din       <= r_shift;
              r_control   <= r_ctrl_shadow;
              r_din_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_idle == IDLE_LAST) begin
          r_frame_err <= 1'b1;
          r_state     <= S_IDLE;
          r_idle      <= '0;
        end else begin
          r_idle <= r_idle + IW'(1);
        end
      end else begin
        r_idle <= '0;
      end
    end
  end

  assign din       = r_din;
  assign din_valid = r_din_valid;
  assign control   = r_control;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Testbench for uart_frame_assembler: directed frame scenarios followed by
// randomized frames, checked every cycle against a queue-based frame model.
module tb_uart_frame_assembler;

  localparam int         W    = 128;
  localparam int         N    = W / 8;
  localparam int         TO   = 16;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef FRAME_CHECKSUM_EN
  localparam int FLEN = N + 3;
`else
  localparam int FLEN = N + 2;
`endif
  localparam logic [W-1:0] PAT = 128'h000102030405060708090A0B0C0D0E0F;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [W-1:0] din;
  logic         din_valid;
  logic [5:0]   control;
  logic         frame_err;

  always #5 clk = ~clk;

  uart_frame_assembler #(
    .WIDTH_DIN     (W),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .din      (din),
    .din_valid(din_valid),
    .control  (control),
    .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes of the frame collected so far and idle gap length.
  logic [7:0]   m_frame[$];
  int           m_gap = 0;
  logic [W-1:0] e_din = '0;
  logic [5:0]   e_ctrl = '0;
  bit           e_valid = 1'b0;
  bit           e_err = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    logic [W-1:0] d;
    logic [7:0]   c;
    bit           ok;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (v) begin
      m_gap = 0;
      if (m_frame.size() == 0) begin
        if (b == SYNC) m_frame.push_back(b);
      end else begin
        m_frame.push_back(b);
        if (m_frame.size() == 2 && b[7:6] != 2'b00) begin
          e_err = 1'b1;
          m_frame.delete();
        end else if (m_frame.size() == FLEN) begin
          d = '0;
          for (int i = 0; i < N; i++) d = (d << 8) | W'(m_frame[2 + i]);
          ok = 1'b1;
`ifdef FRAME_CHECKSUM_EN
          begin
            logic [7:0] x;
            x = '0;
            for (int i = 1; i <= N + 1; i++) x = x ^ m_frame[i];
            ok = (x == m_frame[N + 2]);
          end
`endif
          if (ok) begin
            c       = m_frame[1];
            e_valid = 1'b1;
            e_din   = d;
            e_ctrl  = c[5:0];
          end else begin
            e_err = 1'b1;
          end
          m_frame.delete();
        end
      end
    end else if (m_frame.size() != 0) begin
      m_gap++;
      if (m_gap >= TO) begin
        e_err = 1'b1;
        m_frame.delete();
        m_gap = 0;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    @(posedge clk);
    model_step(v, b);
    #1;
    check("din_valid", W'(din_valid), W'(e_valid));
    check("frame_err", W'(frame_err), W'(e_err));
    check("din", din, e_din);
    check("control", W'(control), W'(e_ctrl));
  endtask

  task automatic send(input logic [7:0] b, input int sp);
    cycle(1'b1, b);
    for (int k = 1; k < sp; k++) cycle(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [W-1:0] pl, input int sp,
                            input bit bad_chk);
    logic [7:0] x;
    logic [7:0] b;
    send(SYNC, sp);
    send(c, sp);
    x = c;
    for (int i = 0; i < N; i++) begin
      b = pl[W-1-8*i -: 8];
      x = x ^ b;
      send(b, sp);
    end
`ifdef FRAME_CHECKSUM_EN
    send(bad_chk ? (x ^ 8'h01) : x, sp);
`else
    if (bad_chk) x = '0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_frame.delete();
    m_gap   = 0;
    e_din   = '0;
    e_ctrl  = '0;
    e_valid = 1'b0;
    e_err   = 1'b0;
    check("rst_din", din, '0);
    check("rst_control", W'(control), '0);
    check("rst_din_valid", W'(din_valid), '0);
    check("rst_frame_err", W'(frame_err), '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_frame();
    logic [7:0]   fb[FLEN];
    logic [7:0]   c;
    logic [7:0]   nz;
    logic [W-1:0] pl;
    logic [7:0]   x;
    int           sp;
    int           gpos;
    sp = $urandom_range(1, 4);
    if ($urandom % 4 == 0) begin
      nz = 8'($urandom);
      if (nz == SYNC) nz = 8'h00;
      send(nz, sp);
    end
    c  = {(($urandom % 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 6'($urandom)};
    pl = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom % 3 == 0) pl[71:64] = SYNC;
    fb[0] = SYNC;
    fb[1] = c;
    x = c;
    for (int i = 0; i < N; i++) begin
      fb[2 + i] = pl[W-1-8*i -: 8];
      x = x ^ fb[2 + i];
    end
`ifdef FRAME_CHECKSUM_EN
    fb[N + 2] = (($urandom % 5) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
`endif
    gpos = (($urandom % 5) == 0) ? int'($urandom_range(0, FLEN - 2)) : -1;
    for (int i = 0; i < FLEN; i++)
      send(fb[i], (i == gpos) ? int'($urandom_range(TO - 1, TO + 1)) : sp);
  endtask

  initial begin
    logic [W-1:0] pl;
    do_reset();

    // Reset in the middle of a payload after a good frame.
    send_frame(8'h3F, {$urandom, $urandom, $urandom, $urandom}, 4, 1'b0);
    send(SYNC, 4);
    send(8'h01, 4);
    for (int i = 0; i < 5; i++) send(8'(i), 4);
    do_reset();
    send_frame(8'h01, PAT, 4, 1'b0);
    check("t1_din", din, PAT);
    check("t1_control", W'(control), W'(6'h01));

    // Back-to-back frames, rx_valid every cycle.
    send_frame(8'h02, 128'h101112131415161718191A1B1C1D1E1F, 1, 1'b0);
    send_frame(8'h3F, '1, 1, 1'b0);
    check("t2_din", din, '1);
    check("t2_control", W'(control), W'(6'h3F));

    // Noise byte, bad CTRL, then a good frame.
    send(8'h00, 4);
    send(SYNC, 4);
    send(8'hC1, 4);
    send_frame(8'h00, PAT, 4, 1'b0);
    check("t3_din", din, PAT);
    check("t3_control", W'(control), W'(6'h00));

    // Timeout mid-payload, then bytes landing exactly on the expiry cycle.
    send(SYNC, 4);
    send(8'h05, 4);
    send(8'h11, 4);
    send(8'h22, 4);
    send(8'h33, 1);
    for (int k = 0; k < TO + 2; k++) cycle(1'b0, 8'h00);
    check("t4_din_kept", din, PAT);
    send_frame(8'h05, PAT ^ 128'h1, TO, 1'b0);
    check("t4_din_slow", din, PAT ^ 128'h1);

`ifdef FRAME_CHECKSUM_EN
    send_frame(8'h01, PAT, 4, 1'b0);
    send_frame(8'h02, ~PAT, 4, 1'b1);
    check("t5_din_kept", din, PAT);
`endif

    // SYNC value inside the payload is data.
    pl = PAT;
    pl[71:64] = SYNC;
    send_frame(8'h06, pl, 2, 1'b0);
    check("t6_byte7", W'(din[71:64]), W'(SYNC));

    for (int f = 0; f < 300; f++) rand_frame();
    for (int k = 0; k < TO + 4; k++) cycle(1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
